// File: rtl/hamming_pkg.sv
// Shared codeword layout and syndrome columns for the 8-bit Hamming encoder/decoder pair.
// Layout (MSB..LSB): P4 D4 D3 D2 P3 D1 P2 P1.
package hamming_pkg;

  typedef logic [7:0] codeword_t;
  typedef logic [3:0] syndrome_t;

  localparam int unsigned P1_POS = 0;
  localparam int unsigned P2_POS = 1;
  localparam int unsigned D1_POS = 2;
  localparam int unsigned P3_POS = 3;
  localparam int unsigned D2_POS = 4;
  localparam int unsigned D3_POS = 5;
  localparam int unsigned D4_POS = 6;
  localparam int unsigned P4_POS = 7;

  // Every column has odd weight, so any even-weight nonzero syndrome is a double error.
  localparam syndrome_t COL_P1 = 4'b0001;
  localparam syndrome_t COL_P2 = 4'b0010;
  localparam syndrome_t COL_P3 = 4'b0100;
  localparam syndrome_t COL_P4 = 4'b1000;
  localparam syndrome_t COL_D1 = 4'b1011;
  localparam syndrome_t COL_D2 = 4'b1101;
  localparam syndrome_t COL_D3 = 4'b1110;
  localparam syndrome_t COL_D4 = 4'b0111;

  function automatic codeword_t flip_mask(input syndrome_t syn);
    codeword_t m;
    m = '0;
    case (syn)
      COL_P1:  m[P1_POS] = 1'b1;
      COL_P2:  m[P2_POS] = 1'b1;
      COL_P3:  m[P3_POS] = 1'b1;
      COL_P4:  m[P4_POS] = 1'b1;
      COL_D1:  m[D1_POS] = 1'b1;
      COL_D2:  m[D2_POS] = 1'b1;
      COL_D3:  m[D3_POS] = 1'b1;
      COL_D4:  m[D4_POS] = 1'b1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/hamming_syndrome.sv
// Combinational syndrome {S4,S3,S2,S1} of an 8-bit codeword.
module hamming_syndrome
  import hamming_pkg::*;
(
  input  codeword_t word,
  output syndrome_t syn
);

  assign syn[0] = word[P1_POS] ^ word[D1_POS] ^ word[D2_POS] ^ word[D4_POS];
  assign syn[1] = word[P2_POS] ^ word[D1_POS] ^ word[D3_POS] ^ word[D4_POS];
  assign syn[2] = word[P3_POS] ^ word[D2_POS] ^ word[D3_POS] ^ word[D4_POS];
  assign syn[3] = word[P4_POS] ^ word[D1_POS] ^ word[D2_POS] ^ word[D3_POS];

endmodule

// File: rtl/hamming_decoder.sv
// Two-stage SEC-DED decoder for the 8-bit Hamming code with saturating error counters.
module hamming_decoder
  import hamming_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       data_in,
  input  logic             clr_counts,
  output logic             out_valid,
  output logic [3:0]       data_out,
  output logic [3:0]       syndrome,
  output logic             err_corrected,
  output logic             err_uncorrectable,
  output logic [CNT_W-1:0] corr_count,
  output logic [CNT_W-1:0] uncorr_count
);

  syndrome_t syn_in;
  logic      s1_valid;
  codeword_t s1_word;
  syndrome_t s1_syn;

  codeword_t fixed_word;
  logic      is_single;
  logic      is_double;

  hamming_syndrome u_syndrome (
    .word (data_in),
    .syn  (syn_in)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_word  <= '0;
      s1_syn   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_word <= data_in;
        s1_syn  <= syn_in;
      end
    end
  end

  // Odd weight always names exactly one column; even nonzero weight leaves the mask empty.
  assign is_single  = ^s1_syn;
  assign is_double  = (s1_syn != '0) && !(^s1_syn);
  assign fixed_word = s1_word ^ flip_mask(s1_syn);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid         <= 1'b0;
      data_out          <= '0;
      syndrome          <= '0;
      err_corrected     <= 1'b0;
      err_uncorrectable <= 1'b0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        data_out          <= {fixed_word[D4_POS], fixed_word[D3_POS],
                              fixed_word[D2_POS], fixed_word[D1_POS]};
        syndrome          <= s1_syn;
        err_corrected     <= is_single;
        err_uncorrectable <= is_double;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else if (clr_counts) begin
      corr_count   <= '0;
      uncorr_count <= '0;
    end else begin
      if (out_valid && err_corrected && (corr_count != '1))
        corr_count <= corr_count + 1'b1;
      if (out_valid && err_uncorrectable && (uncorr_count != '1))
        uncorr_count <= uncorr_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_hamming_decoder.sv
// Directed self-checking bench for hamming_decoder (counters built 2 bits wide to reach saturation).
module tb_hamming_decoder;

  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [7:0]       data_in;
  logic             clr_counts;
  logic             out_valid;
  logic [3:0]       data_out;
  logic [3:0]       syndrome;
  logic             err_corrected;
  logic             err_uncorrectable;
  logic [CNT_W-1:0] corr_count;
  logic [CNT_W-1:0] uncorr_count;

  int tests;
  int failed;

  localparam logic [3:0] COL [8] = '{4'h1, 4'h2, 4'hB, 4'h4, 4'hD, 4'hE, 4'h7, 4'h8};

  hamming_decoder #(.CNT_W(CNT_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .data_in           (data_in),
    .clr_counts        (clr_counts),
    .out_valid         (out_valid),
    .data_out          (data_out),
    .syndrome          (syndrome),
    .err_corrected     (err_corrected),
    .err_uncorrectable (err_uncorrectable),
    .corr_count        (corr_count),
    .uncorr_count      (uncorr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for a cycle; returns when its result is on the outputs.
  task automatic send(input logic [7:0] w);
    in_valid = 1'b1;
    data_in  = w;
    step();
    in_valid = 1'b0;
    step();
  endtask

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic d1, d2, d3, d4;
    {d4, d3, d2, d1} = d;
    return {d1 ^ d2 ^ d3, d4, d3, d2, d2 ^ d3 ^ d4, d1, d1 ^ d3 ^ d4, d1 ^ d2 ^ d4};
  endfunction

  initial begin
    logic [7:0] w;
    tests      = 0;
    failed     = 0;
    rst        = 1'b1;
    in_valid   = 1'b0;
    data_in    = '0;
    clr_counts = 1'b0;
    #2;
    check("rst_out_valid", {7'd0, out_valid}, 8'd0);
    check("rst_data", {4'd0, data_out}, 8'd0);
    check("rst_syn", {4'd0, syndrome}, 8'd0);
    check("rst_corr", {7'd0, err_corrected}, 8'd0);
    check("rst_uncorr", {7'd0, err_uncorrectable}, 8'd0);
    check("rst_corr_cnt", {6'd0, corr_count}, 8'd0);
    check("rst_uncorr_cnt", {6'd0, uncorr_count}, 8'd0);
    step();
    rst = 1'b0;
    step();

    // Clean word
    in_valid = 1'b1;
    data_in  = 8'h55;
    step();
    in_valid = 1'b0;
    check("clean_latency1", {7'd0, out_valid}, 8'd0);
    step();
    check("clean_valid", {7'd0, out_valid}, 8'd1);
    check("clean_data", {4'd0, data_out}, 8'h0B);
    check("clean_syn", {4'd0, syndrome}, 8'h00);
    check("clean_corr", {7'd0, err_corrected}, 8'd0);
    check("clean_uncorr", {7'd0, err_uncorrectable}, 8'd0);
    step();
    check("clean_valid_drop", {7'd0, out_valid}, 8'd0);
    check("clean_corr_cnt", {6'd0, corr_count}, 8'd0);
    check("clean_uncorr_cnt", {6'd0, uncorr_count}, 8'd0);

    // Single data-bit error on D2
    send(8'h45);
    check("d2_data", {4'd0, data_out}, 8'h0B);
    check("d2_syn", {4'd0, syndrome}, 8'h0D);
    check("d2_corr", {7'd0, err_corrected}, 8'd1);
    check("d2_uncorr", {7'd0, err_uncorrectable}, 8'd0);
    step();
    check("d2_corr_cnt", {6'd0, corr_count}, 8'd1);
    check("idle_hold_data", {4'd0, data_out}, 8'h0B);
    check("idle_hold_syn", {4'd0, syndrome}, 8'h0D);
    check("idle_hold_flag", {7'd0, err_corrected}, 8'd1);
    check("idle_valid", {7'd0, out_valid}, 8'd0);
    step();
    check("idle_no_recount", {6'd0, corr_count}, 8'd1);

    // Every single-bit flip of 8'h55
    for (int i = 0; i < 8; i++) begin
      w = 8'h55 ^ (8'h01 << i);
      send(w);
      check($sformatf("single%0d_valid", i), {7'd0, out_valid}, 8'd1);
      check($sformatf("single%0d_data", i), {4'd0, data_out}, 8'h0B);
      check($sformatf("single%0d_syn", i), {4'd0, syndrome}, {4'd0, COL[i]});
      check($sformatf("single%0d_corr", i), {7'd0, err_corrected}, 8'd1);
      check($sformatf("single%0d_uncorr", i), {7'd0, err_uncorrectable}, 8'd0);
    end
    step();
    check("sweep_corr_sat", {6'd0, corr_count}, 8'd3);

    // Saturation from zero over 5 corrected words
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    check("clr_corr_cnt", {6'd0, corr_count}, 8'd0);
    for (int k = 1; k <= 5; k++) begin
      send(8'hD5);
      check($sformatf("p4_syn_%0d", k), {4'd0, syndrome}, 8'h08);
      check($sformatf("p4_data_%0d", k), {4'd0, data_out}, 8'h0B);
      step();
      check($sformatf("sat_cnt_%0d", k), {6'd0, corr_count}, (k > 3) ? 8'd3 : 8'(k));
    end

    // Double error on P1,P2: raw data passes through, which is 4'hB for this word
    send(8'h56);
    check("dbl_syn", {4'd0, syndrome}, 8'h03);
    check("dbl_uncorr", {7'd0, err_uncorrectable}, 8'd1);
    check("dbl_corr", {7'd0, err_corrected}, 8'd0);
    check("dbl_data", {4'd0, data_out}, 8'h0B);
    step();
    check("dbl_uncorr_cnt", {6'd0, uncorr_count}, 8'd1);

    // All 28 bit pairs of 8'h55
    for (int i = 0; i < 8; i++) begin
      for (int j = i + 1; j < 8; j++) begin
        w = 8'h55 ^ (8'h01 << i) ^ (8'h01 << j);
        send(w);
        check($sformatf("pair%0d%0d_corr", i, j), {7'd0, err_corrected}, 8'd0);
        check($sformatf("pair%0d%0d_uncorr", i, j), {7'd0, err_uncorrectable}, 8'd1);
        check($sformatf("pair%0d%0d_syn", i, j), {4'd0, syndrome}, {4'd0, COL[i] ^ COL[j]});
        check($sformatf("pair%0d%0d_data", i, j), {4'd0, data_out}, {4'd0, w[6], w[5], w[4], w[2]});
      end
    end
    step();
    check("pair_uncorr_sat", {6'd0, uncorr_count}, 8'd3);

    // Clear coinciding with a corrected output
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    send(8'h54);
    step();
    check("pre_clr_cnt", {6'd0, corr_count}, 8'd1);
    send(8'h57);
    check("clr_race_corr", {7'd0, err_corrected}, 8'd1);
    clr_counts = 1'b1;
    step();
    clr_counts = 1'b0;
    check("clr_race_cnt", {6'd0, corr_count}, 8'd0);
    check("clr_race_uncorr_cnt", {6'd0, uncorr_count}, 8'd0);

    // Back-to-back stream of all 16 encoded words
    for (int n = 0; n < 18; n++) begin
      if (n < 16) begin
        in_valid = 1'b1;
        data_in  = encode(4'(n));
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (n == 0) begin
        check("stream_lead", {7'd0, out_valid}, 8'd0);
      end else if (n <= 16) begin
        check($sformatf("stream%0d_valid", n - 1), {7'd0, out_valid}, 8'd1);
        check($sformatf("stream%0d_data", n - 1), {4'd0, data_out}, 8'(n - 1));
        check($sformatf("stream%0d_syn", n - 1), {4'd0, syndrome}, 8'd0);
      end else begin
        check("stream_tail", {7'd0, out_valid}, 8'd0);
      end
    end

    // Reset with words in flight
    send(8'h54);
    step();
    check("pre_rst_cnt", {6'd0, corr_count}, 8'd1);
    in_valid = 1'b1;
    data_in  = encode(4'h6);
    step();
    data_in = encode(4'h9);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_valid", {7'd0, out_valid}, 8'd0);
    check("mid_rst_data", {4'd0, data_out}, 8'd0);
    check("mid_rst_syn", {4'd0, syndrome}, 8'd0);
    check("mid_rst_corr", {7'd0, err_corrected}, 8'd0);
    check("mid_rst_cnt", {6'd0, corr_count}, 8'd0);
    in_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
    step();
    check("post_rst_valid1", {7'd0, out_valid}, 8'd0);
    step();
    check("post_rst_valid2", {7'd0, out_valid}, 8'd0);
    in_valid = 1'b1;
    data_in  = encode(4'hC);
    step();
    in_valid = 1'b0;
    check("post_rst_lat1", {7'd0, out_valid}, 8'd0);
    step();
    check("post_rst_valid", {7'd0, out_valid}, 8'd1);
    check("post_rst_data", {4'd0, data_out}, 8'h0C);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
